// File: rtl/adder_result_stage.sv
// Registered result stage behind the 16-bit adder: 2-entry skid buffer, N/Z/C/V flags,
// delivered-result status and transfer counter. Define OVERFLOW_FLAG_EN to enable the V flag.
module adder_result_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] sum,
  input  logic        carry_out,
  input  logic        a_msb,
  input  logic        b_msb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic [3:0]  status_flags,
  output logic [15:0] xfer_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t      state, next_state;
  logic [15:0] main_result, skid_result;
  logic [3:0]  main_flags, skid_flags, in_flags;
  logic        push, pop;
  logic        load_main_in, load_main_skid, load_skid;
  logic        overflow;

`ifdef OVERFLOW_FLAG_EN
  assign overflow = (a_msb == b_msb) & (sum[15] != a_msb);
`else
  logic unused_msbs;
  assign unused_msbs = a_msb ^ b_msb;
  assign overflow    = 1'b0;
`endif

  assign in_flags   = {sum[15], (sum == 16'h0000), carry_out, overflow};
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_valid  = (state != EMPTY);
  assign out_result = main_result;
  assign out_flags  = main_flags;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: if (push) begin
        load_main_in = 1'b1;
        next_state   = ONE;
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: if (pop) begin
        load_main_skid = 1'b1;
        next_state     = ONE;
      end
      default: next_state = EMPTY;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
    end
  end

  // NOTE: the data registers are reset too, so out_result/out_flags never carry X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_result <= '0;
      main_flags  <= '0;
      skid_result <= '0;
      skid_flags  <= '0;
    end else begin
      if (load_main_in) begin
        main_result <= sum;
        main_flags  <= in_flags;
      end else if (load_main_skid) begin
        main_result <= skid_result;
        main_flags  <= skid_flags;
      end
      if (load_skid) begin
        skid_result <= sum;
        skid_flags  <= in_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_flags <= '0;
      xfer_count   <= '0;
    end else if (pop) begin
      status_flags <= main_flags;
      xfer_count   <= xfer_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: queue-based reference model, directed and random stimulus.
module tb_adder_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, carry_out, a_msb, b_msb;
  logic        out_valid, out_ready;
  logic [15:0] sum, out_result, xfer_count;
  logic [3:0]  out_flags, status_flags;

  int errors = 0;
  int checks = 0;

  logic [19:0] q[$];
  logic [3:0]  m_status;
  logic [15:0] m_count;

  always #5 clk = ~clk;

  adder_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carry_out(carry_out), .a_msb(a_msb), .b_msb(b_msb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .status_flags(status_flags), .xfer_count(xfer_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [15:0] s, input logic c,
                                             input logic a, input logic b);
    logic v;
`ifdef OVERFLOW_FLAG_EN
    v = (a == b) && (s[15] != a);
`else
    v = 1'b0;
`endif
    return {s[15], s == 16'h0000, c, v};
  endfunction

  task automatic compare();
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      check("out_result", {16'd0, out_result}, {16'd0, q[0][19:4]});
      check("out_flags", {28'd0, out_flags}, {28'd0, q[0][3:0]});
    end
    check("status_flags", {28'd0, status_flags}, {28'd0, m_status});
    check("xfer_count", {16'd0, xfer_count}, {16'd0, m_count});
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare just after.
  task automatic step(input logic v, input logic [15:0] s, input logic c,
                      input logic a, input logic b, input logic ordy);
    logic do_pop, do_push;
    @(negedge clk);
    in_valid = v; sum = s; carry_out = c; a_msb = a; b_msb = b; out_ready = ordy;
    @(posedge clk);
    do_pop  = (q.size() > 0) && ordy;
    do_push = v && (q.size() < 2);
    if (do_pop) begin
      m_status = q[0][3:0];
      m_count  = m_count + 16'd1;
      void'(q.pop_front());
    end
    if (do_push) q.push_back({s, model_flags(s, c, a, b)});
    #1;
    compare();
  endtask

  task automatic reset_checks();
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_result", {16'd0, out_result}, 32'd0);
    check("rst out_flags", {28'd0, out_flags}, 32'd0);
    check("rst status_flags", {28'd0, status_flags}, 32'd0);
    check("rst xfer_count", {16'd0, xfer_count}, 32'd0);
  endtask

  initial begin
    logic [3:0] exp_first;
`ifdef OVERFLOW_FLAG_EN
    exp_first = 4'b1001;
`else
    exp_first = 4'b1000;
`endif
    rst_n = 1'b0; in_valid = 1'b0; sum = '0; carry_out = 1'b0;
    a_msb = 1'b0; b_msb = 1'b0; out_ready = 1'b0;
    m_status = '0; m_count = '0;
    repeat (2) @(posedge clk);
    #1 reset_checks();
    @(negedge clk) rst_n = 1'b1;

    // 0x7FFF + 0x0001
    step(1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1 out_result", {16'd0, out_result}, 32'h8000);
    check("t1 out_flags", {28'd0, out_flags}, {28'd0, exp_first});
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1 status_flags", {28'd0, status_flags}, {28'd0, exp_first});
    check("t1 xfer_count", {16'd0, xfer_count}, 32'd1);

    // 0xFFFF + 0x0001
    step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t2 out_flags", {28'd0, out_flags}, 32'b0110);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: third push is refused while full
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3 in_ready full", {31'd0, in_ready}, 32'd0);
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3 head held", {16'd0, out_result}, 32'h0001);
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3 in_ready back", {31'd0, in_ready}, 32'd1);
    check("t3 second out", {16'd0, out_result}, 32'h0002);
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3 third out", {16'd0, out_result}, 32'h0003);
    check("t3 xfer_count", {16'd0, xfer_count}, 32'd4);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    // Streaming at one entry per cycle
    for (int i = 0; i < 20; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4 xfer_count", {16'd0, xfer_count}, 32'd25);

    // Random traffic, both sides throttled
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));

    // Drive the counter to 0xFFFF, then one more pop wraps it
    while (m_count != 16'hFFFF)
      step(1'b1, 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap xfer_count", {16'd0, xfer_count}, 32'd0);

    // Reset while full discards everything
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_checks();
    q.delete(); m_status = '0; m_count = '0;
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post-rst out_result", {16'd0, out_result}, 32'h1234);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post-rst xfer_count", {16'd0, xfer_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
